hamming_encoder: RTL

HAMMING_ENCODER -- requirements
Module: hamming_encoder

---
 rtl/hamming_encoder_pkg.sv | 42 ++++
 rtl/hamming_parity_gen.sv | 53 +++++
 rtl/hamming_encoder.sv | 92 +++++++++
 3 files changed

// File: rtl/hamming_encoder_pkg.sv
// Shared definitions for the Hamming encoder/decoder pair: code modes, per-mode
// widths and the info-bit to code-position mapping.
package hamming_encoder_pkg;

  typedef enum logic [1:0] {
    MOD_8_4   = 2'b00,
    MOD_16_11 = 2'b01,
    MOD_32_26 = 2'b10,
    MOD_RSVD  = 2'b11
  } mod_e;

  localparam int INFO_W_8_4     = 4;
  localparam int PARITY_W_8_4   = 4;
  localparam int INFO_W_16_11   = 11;
  localparam int PARITY_W_16_11 = 5;
  localparam int INFO_W_32_26   = 26;
  localparam int PARITY_W_32_26 = 6;

  localparam int INFO_W_MAX   = 26;
  localparam int PARITY_W_MAX = 6;
  localparam int CODE_W_MAX   = 32;

  localparam int PAD_W_8_4   = CODE_W_MAX - INFO_W_8_4 - PARITY_W_8_4;
  localparam int PAD_W_16_11 = CODE_W_MAX - INFO_W_16_11 - PARITY_W_16_11;
  localparam int PAD_W_32_26 = CODE_W_MAX - INFO_W_32_26 - PARITY_W_32_26;

  // Position of info bit j: the j-th integer >= 3 that is not a power of two.
  function automatic logic [5:0] info_pos(input int j);
    logic [5:0] pos;
    int n;
    pos = '0;
    n   = 0;
    for (int v = 3; v < 64; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (n == j) pos = 6'(v);
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational parity generator: Hamming check bits plus an overall even-parity
// bit in the top parity position of the selected mode.
module hamming_parity_gen
  import hamming_encoder_pkg::*;
(
  input  logic [INFO_W_MAX-1:0]   info,
  input  mod_e                    mode,
  output logic [PARITY_W_MAX-1:0] parity
);

  int                     k_w;
  logic [INFO_W_MAX-1:0]  info_m;
  logic [PARITY_W_MAX-1:0] syn;
  logic [5:0]             pos;
  logic                   ovr;

  always_comb begin
    k_w    = 0;
    info_m = '0;
    syn    = '0;
    pos    = '0;
    ovr    = 1'b0;
    parity = '0;

    case (mode)
      MOD_8_4:   k_w = INFO_W_8_4;
      MOD_16_11: k_w = INFO_W_16_11;
      MOD_32_26: k_w = INFO_W_32_26;
      default:   k_w = 0;
    endcase

    for (int j = 0; j < INFO_W_MAX; j++)
      info_m[j] = (j < k_w) ? info[j] : 1'b0;

    // Highest position per mode stays below 2**(P-1), so the top bit is free.
    for (int j = 0; j < INFO_W_MAX; j++) begin
      pos = info_pos(j);
      for (int k = 0; k < PARITY_W_MAX - 1; k++)
        syn[k] = syn[k] ^ (info_m[j] & pos[k]);
    end

    ovr    = (^info_m) ^ (^syn);
    parity = syn;

    case (mode)
      MOD_8_4:   parity[PARITY_W_8_4-1]   = ovr;
      MOD_16_11: parity[PARITY_W_16_11-1] = ovr;
      MOD_32_26: parity[PARITY_W_32_26-1] = ovr;
      default:   parity = '0;
    endcase
  end

endmodule

// File: rtl/hamming_encoder.sv
// Two-stage valid/ready Hamming encoder with error-injection mask and an
// output word counter.
module hamming_encoder
  import hamming_encoder_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_INFO_WIDTH-1:0]     data_in,
  input  logic [1:0]                    mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] inj_mask,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic                          bad_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   word_count
);

  logic                          s1_valid;
  logic [MAX_INFO_WIDTH-1:0]     s1_data;
  mod_e                          s1_mod;
  logic [MAX_CODEWORD_WIDTH-1:0] s1_mask;
  logic                          s2_load;
  logic [PARITY_W_MAX-1:0]       par;
  logic [MAX_CODEWORD_WIDTH-1:0] cw;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;

  hamming_parity_gen u_parity (
    .info   (s1_data),
    .mode   (s1_mod),
    .parity (par)
  );

  always_comb begin
    cw = '0;
    case (s1_mod)
      MOD_8_4:
        cw[INFO_W_8_4+PARITY_W_8_4-1:0] =
          {s1_data[INFO_W_8_4-1:0], par[PARITY_W_8_4-1:0]};
      MOD_16_11:
        cw[INFO_W_16_11+PARITY_W_16_11-1:0] =
          {s1_data[INFO_W_16_11-1:0], par[PARITY_W_16_11-1:0]};
      MOD_32_26:
        cw[INFO_W_32_26+PARITY_W_32_26-1:0] =
          {s1_data[INFO_W_32_26-1:0], par[PARITY_W_32_26-1:0]};
      default: cw = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mod   <= MOD_8_4;
      s1_mask  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= data_in;
        s1_mod  <= mod_e'(mod);
        s1_mask <= inj_mask;
      end
    end
  end

  // Reserved mode emits an all-zero word; the mask is deliberately not applied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      bad_mod    <= 1'b0;
      word_count <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        bad_mod   <= (s1_mod == MOD_RSVD);
        data_out  <= (s1_mod == MOD_RSVD) ? '0 : (cw ^ s1_mask);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready)
        word_count <= word_count + 16'd1;
    end
  end

endmodule
